mux_ext_pipe: RTL and testbench

Parametrised N-way field selector with sign/zero extension, wrapped in a valid/ready handshake and a 2-entry output buffer. It is the generalised successor of the fixed 4×8-bit registered sign-extending mux. It sits between the register-file/immediate sources and the ALU operand path, where back-pressure from downstream stages must be absorbed without dropping operands.

---
 rtl/mux_ext_pipe.sv | 104 ++++++++++
 tb/tb_mux_ext_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_ext_pipe.sv
// mux_ext_pipe: N-way field selector with sign/zero extension, behind a
// valid/ready handshake and a 2-entry output FIFO.
// An out-of-range select is still accepted. It stores a zero result with
// the error flag set.
// in_ready is derived from registered occupancy only, so it never depends
// combinationally on out_ready.
module mux_ext_pipe #(
  parameter int N     = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int SEL_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    select,
  input  logic                sign_mode,
  input  logic [N*IN_W-1:0]   data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    o,
  output logic                o_err
);

  // Widen a field to OUT_W. The upper bits are a copy of the field MSB
  // (sign_mode = 1) or zeros. When OUT_W == IN_W the loop is empty.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] field,
                                              input logic            sign);
    logic [OUT_W-1:0] r;
    r = OUT_W'(field);
    for (int i = IN_W; i < OUT_W; i++) begin
      r[i] = sign & field[IN_W-1];
    end
    return r;
  endfunction

  logic [IN_W-1:0]  field_p0;
  logic             in_range_p0;
  logic [OUT_W-1:0] ext_p0;

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [OUT_W-1:0] data_mem [2];
  logic             err_mem  [2];

  logic             push;
  logic             pop;

  // Stage p0: pick the selected field and extend it. An unmatched select
  // yields a zero result with the range flag low.
  always_comb begin
    field_p0    = '0;
    in_range_p0 = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (select == SEL_W'(k)) begin
        field_p0    = data_in[k*IN_W +: IN_W];
        in_range_p0 = 1'b1;
      end
    end
    ext_p0 = in_range_p0 ? extend(field_p0, sign_mode) : '0;
  end

  // Handshake is decoded from registered occupancy. The head entry is
  // exposed only while the FIFO is non-empty.
  always_comb begin
    in_ready  = (count != 2'd2);
    out_valid = (count != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    o         = out_valid ? data_mem[rd_ptr] : '0;
    o_err     = out_valid ? err_mem[rd_ptr]  : 1'b0;
  end

  // FIFO state. A simultaneous push and pop writes the tail, advances the
  // head and leaves the count unchanged. Reset flushes every entry at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        err_mem[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= ext_p0;
        err_mem[wr_ptr]  <= ~in_range_p0;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_ext_pipe.sv
// tb_mux_ext_pipe: directed bench for mux_ext_pipe.
// The default instance is checked through a scoreboard of expected
// {err, result} pairs. Two extra instances cover the out-of-range select
// case (N = 3) and a configuration without extension (OUT_W == IN_W).
module tb_mux_ext_pipe;

  logic clk;
  logic reset_n;

  // Default instance: N=4, IN_W=8, OUT_W=32, SEL_W=2
  logic        in_valid, in_ready, sign_mode, out_valid, out_ready, o_err;
  logic [1:0]  select;
  logic [31:0] data_in, o;

  // N=3 instance
  logic        in_valid3, in_ready3, sign3, out_valid3, out_ready3, o_err3;
  logic [1:0]  select3;
  logic [23:0] data3;
  logic [31:0] o3;

  // N=8, IN_W=16, OUT_W=16 instance
  logic         in_validw, in_readyw, signw, out_validw, out_readyw, o_errw;
  logic [2:0]   selectw;
  logic [127:0] dataw;
  logic [15:0]  ow;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [32:0] exp_next;
  logic [32:0] sb[$];

  mux_ext_pipe dut (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .sign_mode(sign_mode), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .o_err(o_err)
  );

  mux_ext_pipe #(.N(3), .IN_W(8), .OUT_W(32), .SEL_W(2)) dut3 (
    .clock(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .select(select3), .sign_mode(sign3), .data_in(data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .o(o3), .o_err(o_err3)
  );

  mux_ext_pipe #(.N(8), .IN_W(16), .OUT_W(16), .SEL_W(3)) dutw (
    .clock(clk), .reset_n(reset_n), .in_valid(in_validw), .in_ready(in_readyw),
    .select(selectw), .sign_mode(signw), .data_in(dataw),
    .out_valid(out_validw), .out_ready(out_readyw), .o(ow), .o_err(o_errw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: compare each popped head entry, then record each accepted push.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL sb_empty got=%h exp=<queued entry>", {o_err, o});
        end
        if (sb.size() > 0) begin
          logic [32:0] e;
          e = sb.pop_front();
          pops++;
          total++;
          assert ({o_err, o} === e) else begin
            bad++;
            $error("FAIL sb_out got=%h exp=%h", {o_err, o}, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_next);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one beat and hold it until it is accepted. Called and returns at posedge+1.
  task automatic push_beat(input logic [31:0] d, input logic [1:0] s,
                           input logic sm, input logic [32:0] e);
    logic acc;
    int   budget;
    in_valid  = 1'b1;
    data_in   = d;
    select    = s;
    sign_mode = sm;
    exp_next  = e;
    budget    = 50;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!acc && budget > 0);
    if (!acc) check("push_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int p0;
    reset_n   = 1'b1;
    in_valid  = 0; select  = 0; sign_mode = 0; data_in = 0; out_ready = 0; exp_next = 0;
    in_valid3 = 0; select3 = 0; sign3 = 0; data3 = 0; out_ready3 = 1;
    in_validw = 0; selectw = 0; signw = 0; dataw = 0; out_readyw = 1;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_o",         64'(o),         64'd0);
    check("rst_o_err",     64'(o_err),     64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // First push with latency of one cycle
    out_ready = 1'b1;
    push_beat(32'h44332211, 2'd0, 1'b0, {1'b0, 32'h00000011});
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_o",     64'(o),         64'h11);

    // Sign / zero extension
    push_beat(32'h7F802211, 2'd2, 1'b1, {1'b0, 32'hFFFFFF80});
    push_beat(32'h7F802211, 2'd2, 1'b0, {1'b0, 32'h00000080});
    push_beat(32'h7F802211, 2'd3, 1'b1, {1'b0, 32'h0000007F});
    @(posedge clk); #1;
    check("drain_empty", 64'(out_valid), 64'd0);

    // Back-pressure: A and B fill the FIFO, C must wait
    out_ready = 1'b0;
    push_beat(32'h04030201, 2'd0, 1'b0, {1'b0, 32'h00000001});
    push_beat(32'h04030201, 2'd1, 1'b0, {1'b0, 32'h00000002});
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head",     64'(o),        64'h1);
    in_valid = 1'b1; data_in = 32'h84030201; select = 2'd3; sign_mode = 1'b1;
    exp_next = {1'b0, 32'hFFFFFF84};
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_head",     64'(o),        64'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("recover_in_ready", 64'(in_ready), 64'd1);
    check("recover_head",     64'(o),        64'h2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("c_head", 64'(o), 64'hFFFFFF84);
    @(posedge clk); #1;
    check("bp_empty", 64'(out_valid), 64'd0);

    // Streaming at count = 1; out_ready stays high on an empty FIFO too
    p0 = pops;
    push_beat(32'h00000001, 2'd0, 1'b0, {1'b0, 32'h00000001});
    for (int i = 1; i < 8; i++) begin
      in_valid = 1'b1; data_in = 32'(i * 16 + 1); select = 2'd0; sign_mode = 1'b0;
      exp_next = {1'b0, 32'(i * 16 + 1)};
      @(posedge clk); #1;
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stream_pops",  64'(pops - p0), 64'd8);
    check("stream_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with the FIFO full
    out_ready = 1'b0;
    push_beat(32'hAABBCCDD, 2'd0, 1'b1, {1'b0, 32'hFFFFFFDD});
    push_beat(32'hAABBCCDD, 2'd1, 1'b1, {1'b0, 32'hFFFFFFCC});
    check("pre_rst_full", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_o",         64'(o),         64'd0);
    check("mid_rst_o_err",     64'(o_err),     64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    push_beat(32'h44332211, 2'd0, 1'b0, {1'b0, 32'h00000011});
    check("post_rst_o", 64'(o), 64'h11);
    @(posedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Out-of-range select on the N=3 instance
    in_valid3 = 1'b1; data3 = 24'h818283; select3 = 2'd3; sign3 = 1'b1;
    @(posedge clk); #1;
    check("oor_valid", 64'(out_valid3), 64'd1);
    check("oor_o",     64'(o3),         64'd0);
    check("oor_err",   64'(o_err3),     64'd1);
    select3 = 2'd1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    check("inr_o",   64'(o3),     64'hFFFFFF82);
    check("inr_err", 64'(o_err3), 64'd0);

    // OUT_W == IN_W: no extension applied
    in_validw = 1'b1; dataw = {16'h8001, 96'h0, 16'h8002}; selectw = 3'd7; signw = 1'b1;
    @(posedge clk); #1;
    check("w_field7", 64'(ow), 64'h8001);
    selectw = 3'd0;
    @(posedge clk); #1;
    in_validw = 1'b0;
    check("w_field0", 64'(ow),     64'h8002);
    check("w_err",    64'(o_errw), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
